// File: rtl/serout_frame_control.sv
// serout_frame_control
//   Frame sequencer for the serial output path. Wraps each byte held in the
//   write register in a start bit (0) and a stop bit (1), sends it LSB first
//   on the SOD line, and drives the Load/Shift strobes of the downstream
//   shift register. The sequencer only advances on bit-time ticks
//   (enp & BitTick).
//
// Ports
//   clk         system clock, the only clock
//   reset       synchronous, active-high reset
//   enp / enn   one-clk pulses on the rising / falling edge of the slow clock
//   BitTick     bit-time boundary, meaningful only together with enp
//   SeroutWr    one-clk pulse, CPU wrote the write register (marks it full)
//   DshiftOut   current LSB presented by the shift register
//   ForceBreak  holds SerOut low while set; does not affect sequencing
//   Load        write-register -> shift-register transfer strobe (one slow period)
//   Shift       shift-register advance strobe (one slow period)
//   SerOut      SOD line
//   SerNeedIrq  one-clk pulse when the write register becomes empty
//   XmitDone    1 = idle with no pending byte
//   fsm_state   debug view of the sequencer state
//
// Strobe handshake: Load and Shift are level strobes held for one slow
// period; the consumer acts on their rising edge. Load rises on the clk edge
// after the tick and falls after the next enp cycle; Shift rises after the
// first enn cycle following the tick and falls after the next enn cycle.

module serout_frame_control (
  input  logic       clk,
  input  logic       reset,
  input  logic       enp,
  input  logic       enn,
  input  logic       BitTick,
  input  logic       SeroutWr,
  input  logic       DshiftOut,
  input  logic       ForceBreak,
  output logic       Load,
  output logic       Shift,
  output logic       SerOut,
  output logic       SerNeedIrq,
  output logic       XmitDone,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] count, count_nxt;
  logic       sod, sod_nxt;
  logic       wr_full, wr_full_nxt;
  logic       shift_pend;
  logic       load_start;
  logic       shift_req;
  logic       tick;
  logic       xmit_done_nxt;

  assign tick      = enp & BitTick;
  assign SerOut    = sod & ~ForceBreak;
  assign fsm_state = state;

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    sod_nxt    = sod;
    load_start = 1'b0;
    shift_req  = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          sod_nxt = 1'b1;
          if (wr_full) begin
            load_start = 1'b1;
            sod_nxt    = 1'b0;
            state_nxt  = ST_START;
          end
        end
        ST_START: begin
          // The byte was loaded one tick ago, so bit 0 is already presented.
          sod_nxt   = DshiftOut;
          count_nxt = 3'd0;
          shift_req = 1'b1;
          state_nxt = ST_DATA;
        end
        ST_DATA: begin
          if (count != 3'd7) begin
            sod_nxt   = DshiftOut;
            count_nxt = count + 3'd1;
            shift_req = 1'b1;
          end else begin
            sod_nxt   = 1'b1;
            state_nxt = ST_STOP;
          end
        end
        ST_STOP: begin
          // A pending byte starts immediately: no idle bit between frames.
          if (wr_full) begin
            load_start = 1'b1;
            sod_nxt    = 1'b0;
            state_nxt  = ST_START;
          end else begin
            sod_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: begin
          sod_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // A write landing on the same clk as the load keeps the register full.
  assign wr_full_nxt   = SeroutWr | (wr_full & ~load_start);
  assign xmit_done_nxt = (state_nxt == ST_IDLE) & ~wr_full_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      count      <= 3'd0;
      sod        <= 1'b1;
      wr_full    <= 1'b0;
      shift_pend <= 1'b0;
      Load       <= 1'b0;
      Shift      <= 1'b0;
      SerNeedIrq <= 1'b0;
      XmitDone   <= 1'b1;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      sod        <= sod_nxt;
      wr_full    <= wr_full_nxt;
      SerNeedIrq <= load_start;
      XmitDone   <= xmit_done_nxt;

      // The tick cycle carries enp, so the clear only fires one slow
      // period later.
      if (load_start) begin
        Load <= 1'b1;
      end else if (enp) begin
        Load <= 1'b0;
      end

      // Shift requests wait for the next falling slow-clock edge.
      if (shift_req) begin
        shift_pend <= 1'b1;
      end else if (shift_pend && enn) begin
        shift_pend <= 1'b0;
      end

      if (Shift && enn) begin
        Shift <= 1'b0;
      end else if (shift_pend && enn) begin
        Shift <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serout_frame_control.sv
// tb_serout_frame_control
//   Bench for serout_frame_control with a behavioural shift register
//   downstream and a bit-position model of the serial frame.

module tb_serout_frame_control;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset       = 1'b1;
  logic       enp         = 1'b0;
  logic       enn         = 1'b0;
  logic       bit_tick    = 1'b0;
  logic       serout_wr   = 1'b0;
  logic       force_break = 1'b0;
  logic       dshift_out;
  logic       load, shift, serout, ser_need_irq, xmit_done;
  logic [1:0] fsm_state;

  logic [7:0] wr_data = 8'h00;
  logic [7:0] wr_reg  = 8'h00;
  logic [7:0] sr      = 8'h00;
  logic       load_q  = 1'b0;
  logic       shift_q = 1'b0;

  assign dshift_out = sr[0];

  serout_frame_control dut (
    .clk        (clk),
    .reset      (reset),
    .enp        (enp),
    .enn        (enn),
    .BitTick    (bit_tick),
    .SeroutWr   (serout_wr),
    .DshiftOut  (dshift_out),
    .ForceBreak (force_break),
    .Load       (load),
    .Shift      (shift),
    .SerOut     (serout),
    .SerNeedIrq (ser_need_irq),
    .XmitDone   (xmit_done),
    .fsm_state  (fsm_state)
  );

  // Downstream write register + shift register (acts on strobe rising edges).
  always @(posedge clk) begin
    if (serout_wr) wr_reg <= wr_data;
    if (load && !load_q) sr <= wr_reg;
    else if (shift && !shift_q) sr <= {1'b0, sr[7:1]};
    load_q  <= load;
    shift_q <= shift;
  end

  // ---------------- slow clock / tick / write driver ----------------
  int         ph          = 0;
  int         slow_cnt    = 0;
  int         gap         = 16;
  int         tick_count  = 0;
  bit         rand_gaps   = 1'b0;
  int         wr_req_cnt  = 0;
  int         wr_done_cnt = 0;
  logic [7:0] wr_req_data = 8'h00;
  bit         wr_sync     = 1'b0;

  always @(negedge clk) begin
    ph  = (ph == 7) ? 0 : ph + 1;
    enp = (ph == 0);
    enn = (ph == 4);
    bit_tick = 1'b0;
    if (enp) begin
      slow_cnt++;
      if (slow_cnt >= gap) begin
        bit_tick = 1'b1;
        slow_cnt = 0;
        tick_count++;
        gap = rand_gaps ? int'($urandom_range(4, 20)) : 16;
      end
    end else begin
      // Garbage outside enp must be ignored.
      bit_tick = 1'($urandom_range(0, 1));
    end
    serout_wr = 1'b0;
    if (wr_done_cnt != wr_req_cnt) begin
      if (wr_sync ? (enp && bit_tick) : !(enp && bit_tick)) begin
        serout_wr   = 1'b1;
        wr_data     = wr_req_data;
        wr_done_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  // Frame position: -1 idle, 0 start bit, 1..8 data bits, 9 stop bit.
  int         m_pos   = -1;
  bit         m_pend  = 1'b0;
  logic [7:0] m_pend_byte = 8'h00;
  logic [7:0] m_frame = 8'h00;
  bit         m_load  = 1'b0;
  bit         m_shift = 1'b0;
  bit         m_shreq = 1'b0;
  bit         m_irq   = 1'b0;
  bit         m_xdone = 1'b1;
  bit         m_sod   = 1'b1;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pos = -1; m_pend = 0; m_load = 0; m_shift = 0; m_shreq = 0;
      m_irq = 0; m_xdone = 1; m_valid = 1;
    end else begin
      m_irq = 0;
      if (m_load && enp) m_load = 0;
      if (m_shreq && enn) begin
        m_shift = 1; m_shreq = 0;
      end else if (m_shift && enn) begin
        m_shift = 0;
      end
      if (enp && bit_tick) begin
        if (m_pos == -1 || m_pos == 9) begin
          if (m_pend) begin
            m_pos = 0; m_frame = m_pend_byte; m_pend = 0; m_load = 1; m_irq = 1;
          end else begin
            m_pos = -1;
          end
        end else begin
          m_pos++;
          if (m_pos <= 8) m_shreq = 1;
        end
      end
      if (serout_wr) begin
        m_pend = 1; m_pend_byte = wr_data;
      end
      m_xdone = (m_pos == -1) && !m_pend;
    end
    if (m_pos == -1 || m_pos == 9) m_sod = 1;
    else if (m_pos == 0)           m_sod = 0;
    else                           m_sod = m_frame[m_pos-1];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Per-cycle compare, strobe edge counters and per-bit SerOut log.
  int   n_load = 0, n_shift = 0, n_irq = 0, load_hi = 0, xd_hi = 0;
  logic p_load = 0, p_shift = 0, p_irq = 0;
  logic [2:0] th = 3'b000;
  logic bit_log [0:4095];
  int   log_n = 0;

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("cyc_load",   load,         m_load);
      chk("cyc_shift",  shift,        m_shift);
      chk("cyc_serout", serout,       m_sod & ~force_break);
      chk("cyc_irq",    ser_need_irq, m_irq);
      chk("cyc_xdone",  xmit_done,    m_xdone);
      if (load === 1'b1 && p_load !== 1'b1)         n_load++;
      if (shift === 1'b1 && p_shift !== 1'b1)       n_shift++;
      if (ser_need_irq === 1'b1 && p_irq !== 1'b1)  n_irq++;
      if (load === 1'b1)      load_hi++;
      if (xmit_done === 1'b1) xd_hi++;
      p_load = load; p_shift = shift; p_irq = ser_need_irq;
      // Sample SerOut a few clks into each bit time.
      if (th[2] && log_n < 4096) begin
        bit_log[log_n] = serout;
        log_n++;
      end
      th = {th[1:0], enp & bit_tick};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [7:0] b, input bit sync);
    int budget;
    wr_req_data = b;
    wr_sync     = sync;
    wr_req_cnt++;
    budget = 0;
    while (wr_done_cnt != wr_req_cnt && budget < 10000) begin
      @(negedge clk);
      budget++;
    end
    if (wr_done_cnt != wr_req_cnt) fail_timeout("write");
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int budget;
    target = tick_count + n;
    budget = 0;
    while (tick_count < target && budget < n * 200) begin
      @(negedge clk);
      budget++;
    end
    if (tick_count < target) fail_timeout("wait_ticks");
    @(negedge clk);
  endtask

  task automatic wait_pos(input int p);
    int budget;
    budget = 0;
    while (m_pos != p && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (m_pos != p) fail_timeout("wait_pos");
  endtask

  task automatic wait_irq(input int target);
    int budget;
    budget = 0;
    while (n_irq < target && budget < 8000) begin
      @(negedge clk);
      budget++;
    end
    if (n_irq < target) fail_timeout("wait_irq");
  endtask

  // Finds the first start bit at or after 'from' and checks 10 bit times.
  task automatic check_bits(input string name, input int from, input logic [9:0] exp,
                            output int at);
    at = -1;
    for (int i = from; i < log_n; i++) begin
      if (bit_log[i] === 1'b0) begin
        at = i;
        break;
      end
    end
    if (at < 0 || at + 10 > log_n) begin
      checks++;
      errors++;
      $display("FAIL %s frame_bits actual=%0d required=10", name, log_n - from);
      at = from;
    end else begin
      for (int k = 0; k < 10; k++)
        chk($sformatf("%s_bit%0d", name, k), 32'(bit_log[at+k]), 32'(exp[k]));
    end
  endtask

  // ---------------- stimulus ----------------
  int s, f1, f2, si, sl, ssh, slh, sx;

  initial begin
    repeat (4) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_serout", serout, 1);
    chk("rst_load",   load,   0);
    chk("rst_shift",  shift,  0);
    chk("rst_irq",    ser_need_irq, 0);
    chk("rst_xdone",  xmit_done, 1);

    // Idle for 50 ticks
    si = n_irq; sl = n_load; ssh = n_shift;
    wait_ticks(50);
    chk("idle_irq",   n_irq - si, 0);
    chk("idle_load",  n_load - sl, 0);
    chk("idle_shift", n_shift - ssh, 0);
    chk("idle_xdone", xmit_done, 1);
    chk("idle_serout", serout, 1);

    // Single frame 0xC9
    s = log_n; si = n_irq; sl = n_load; ssh = n_shift; slh = load_hi;
    write_byte(8'hC9, 1'b0);
    wait_ticks(12);
    check_bits("c9", s, 10'b11_1001_0010, f1);
    chk("c9_loads",   n_load - sl, 1);
    chk("c9_load_w",  load_hi - slh, 8);
    chk("c9_shifts",  n_shift - ssh, 8);
    chk("c9_irq",     n_irq - si, 1);
    chk("c9_xdone",   xmit_done, 1);

    // Back-to-back: 0x5A written during bit 4 of 0xC9
    s = log_n; si = n_irq;
    write_byte(8'hC9, 1'b0);
    @(negedge clk);
    sx = xd_hi;
    wait_pos(5);
    write_byte(8'h5A, 1'b0);
    wait_irq(si + 2);
    wait_pos(9);
    chk("b2b_xdone_low", xd_hi - sx, 0);
    wait_ticks(2);
    check_bits("b2b_f1", s, 10'b11_1001_0010, f1);
    check_bits("b2b_f2", f1 + 10, 10'b10_1011_0100, f2);
    chk("b2b_gap", f2 - f1, 10);
    chk("b2b_irq", n_irq - si, 2);

    // ForceBreak across data bits 2..5 of 0xFF
    s = log_n; ssh = n_shift;
    write_byte(8'hFF, 1'b0);
    wait_pos(3);
    force_break = 1'b1;
    wait_pos(7);
    force_break = 1'b0;
    wait_ticks(4);
    check_bits("brk", s, 10'b11_1000_0110, f1);
    chk("brk_shifts", n_shift - ssh, 8);

    // Reset during bit 3
    write_byte(8'h96, 1'b0);
    wait_pos(4);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("mrst_serout", serout, 1);
    chk("mrst_load",   load,   0);
    chk("mrst_shift",  shift,  0);
    chk("mrst_xdone",  xmit_done, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    s = log_n;
    write_byte(8'hA5, 1'b0);
    wait_ticks(12);
    check_bits("after_rst", s, 10'b11_0100_1010, f1);

    // SeroutWr on the same clk as Load rises
    sx = tick_count;
    while (tick_count == sx) @(negedge clk);
    s = log_n; si = n_irq;
    write_byte(8'h3C, 1'b0);
    write_byte(8'h3C, 1'b1);
    wait_irq(si + 2);
    wait_ticks(12);
    check_bits("coin_f1", s, 10'b10_0111_1000, f1);
    check_bits("coin_f2", f1 + 10, 10'b10_0111_1000, f2);
    chk("coin_gap", f2 - f1, 10);
    chk("coin_irq", n_irq - si, 2);

    // Randomized traffic, gaps and breaks
    rand_gaps = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(20, 400)) @(negedge clk);
      force_break = ($urandom_range(0, 7) == 0);
      write_byte(8'($urandom_range(0, 255)), 1'b0);
    end
    force_break = 1'b0;
    rand_gaps   = 1'b0;
    wait_ticks(24);
    chk("end_xdone", xmit_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
